roic_spi_multi_master: RTL

- Parametrised multi-channel SPI master for ROIC register access. Replaces the fixed 24-bit, single-mode ROIC SPI path.
- Accepts one command at a time over a valid/ready handshake and drives a shared SCK/SDI to NUM_CH ROICs with per-channel active-low chip selects.
- Optionally captures each channel's SDO in parallel for read-back. Sits between the register-map/ROIC sequencer and the ROIC SPI pins.

---
 rtl/roic_spi_multi_master_if.sv | 25 ++
 rtl/roic_spi_multi_master.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/roic_spi_multi_master_if.sv
// Command/response bus between the ROIC register sequencer and the SPI master.
interface roic_spi_multi_master_if #(
  parameter int NUM_CH = 12,
  parameter int DATA_W = 32
) ();
  localparam int LEN_W = $clog2(DATA_W + 1);

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [DATA_W-1:0]        cmd_data;
  logic [LEN_W-1:0]         cmd_len;
  logic [NUM_CH-1:0]        cmd_mask;
  logic                     cmd_read;
  logic                     abort;
  logic                     busy;
  logic                     done;
  logic                     aborted;
  logic                     rsp_valid;
  logic [NUM_CH*DATA_W-1:0] rsp_data;

  modport master (output cmd_valid, cmd_data, cmd_len, cmd_mask, cmd_read, abort,
                  input  cmd_ready, busy, done, aborted, rsp_valid, rsp_data);
  modport slave  (input  cmd_valid, cmd_data, cmd_len, cmd_mask, cmd_read, abort,
                  output cmd_ready, busy, done, aborted, rsp_valid, rsp_data);
endinterface

// File: rtl/roic_spi_multi_master.sv
// Multi-channel SPI master for ROIC register access: shared SCK/SDI, per-channel SEN,
// parallel SDO capture. state | meaning: IDLE wait cmd | SETUP SEN low before SCK |
// SHIFT clocking bits | HOLD SEN low after SCK | GAP SEN high before next cmd
module roic_spi_multi_master #(
  parameter int NUM_CH   = 12,
  parameter int DATA_W   = 32,
  parameter int DIV      = 2,
  parameter int CPOL     = 0,
  parameter int CPHA     = 0,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_GAP   = 2
) (
  input  logic                   clk_20mhz,
  input  logic                   rst,
  roic_spi_multi_master_if.slave bus,
  output logic                   RF_SPI_SCK,
  output logic                   RF_SPI_SDI,
  output logic [NUM_CH-1:0]      RF_SPI_SEN,
  input  logic [NUM_CH-1:0]      RF_SPI_SDO
);
  localparam int               LEN_W    = $clog2(DATA_W + 1);
  localparam int               TMR_W    = 16;
  localparam logic             SCK_IDLE = (CPOL != 0);
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DATA_W);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  state_t state;

  logic [TMR_W-1:0]         cnt;
  logic [TMR_W-1:0]         div_cnt;
  logic [LEN_W:0]           edge_cnt;
  logic [LEN_W-1:0]         len_q;
  logic [NUM_CH-1:0]        mask_q;
  logic                     read_q;
  logic                     abort_q;
  logic [DATA_W-1:0]        sh;
  logic [DATA_W-1:0]        rx [NUM_CH];
  logic                     cmd_ready_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     aborted_q;
  logic                     rsp_valid_q;
  logic [NUM_CH*DATA_W-1:0] rsp_q;
  logic                     sck_q;
  logic                     sdi_q;
  logic [NUM_CH-1:0]        sen_q;

  logic [LEN_W-1:0]  eff_len;
  logic [DATA_W-1:0] aligned;
  logic              edge_odd;
  logic              edge_first;
  logic              edge_last;
  logic              do_sample;
  logic              do_shift;

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_q;
  assign RF_SPI_SCK    = sck_q;
  assign RF_SPI_SDI    = sdi_q;
  assign RF_SPI_SEN    = sen_q;

  always_comb begin
    eff_len = bus.cmd_len;
    if (bus.cmd_len == '0 || bus.cmd_len > FULL_LEN) eff_len = FULL_LEN;
    aligned = bus.cmd_data << (FULL_LEN - eff_len);
  end

  // edge_cnt counts down from 2*len, so the current edge is odd when edge_cnt is even
  always_comb begin
    edge_odd   = ~edge_cnt[0];
    edge_first = (edge_cnt == {len_q, 1'b0});
    edge_last  = (edge_cnt == (LEN_W+1)'(1));
    if (CPHA == 0) begin
      do_sample = edge_odd;
      do_shift  = !edge_odd && !edge_last;
    end else begin
      do_sample = !edge_odd;
      do_shift  = edge_odd && !edge_first;
    end
  end

  always_ff @(posedge clk_20mhz or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      div_cnt     <= '0;
      edge_cnt    <= '0;
      len_q       <= '0;
      mask_q      <= '0;
      read_q      <= 1'b0;
      abort_q     <= 1'b0;
      sh          <= '0;
      for (int i = 0; i < NUM_CH; i++) rx[i] <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      sck_q       <= SCK_IDLE;
      sdi_q       <= 1'b0;
      sen_q       <= '1;
    end else begin
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      if ((state == SETUP || state == SHIFT || state == HOLD) && bus.abort) begin
        state   <= GAP;
        cnt     <= TMR_W'(CS_GAP - 1);
        abort_q <= 1'b1;
        sck_q   <= SCK_IDLE;
        sen_q   <= '1;
        sdi_q   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            if (bus.cmd_valid && cmd_ready_q) begin
              cmd_ready_q <= 1'b0;
              busy_q      <= 1'b1;
              len_q       <= eff_len;
              mask_q      <= bus.cmd_mask;
              read_q      <= bus.cmd_read;
              abort_q     <= 1'b0;
              sh          <= aligned;
              for (int i = 0; i < NUM_CH; i++) rx[i] <= '0;
              if (bus.cmd_mask == '0) begin
                state <= GAP;
                cnt   <= TMR_W'(CS_GAP - 1);
              end else begin
                state <= SETUP;
                cnt   <= TMR_W'(CS_SETUP - 1);
                sen_q <= ~bus.cmd_mask;
                sdi_q <= aligned[DATA_W-1];
              end
            end
          end
          SETUP: begin
            if (cnt == '0) begin
              state    <= SHIFT;
              div_cnt  <= TMR_W'(DIV - 1);
              edge_cnt <= {len_q, 1'b0};
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          SHIFT: begin
            if (div_cnt != '0) begin
              div_cnt <= div_cnt - 1'b1;
            end else begin
              div_cnt  <= TMR_W'(DIV - 1);
              edge_cnt <= edge_cnt - 1'b1;
              sck_q    <= edge_last ? SCK_IDLE : ~sck_q;
              if (do_sample) begin
                for (int i = 0; i < NUM_CH; i++) rx[i] <= {rx[i][DATA_W-2:0], RF_SPI_SDO[i]};
              end
              if (do_shift) begin
                sh    <= sh << 1;
                sdi_q <= sh[DATA_W-2];
              end
              if (edge_last) begin
                state <= HOLD;
                cnt   <= TMR_W'(CS_HOLD - 1);
              end
            end
          end
          HOLD: begin
            if (cnt == '0) begin
              state <= GAP;
              cnt   <= TMR_W'(CS_GAP - 1);
              sen_q <= '1;
              sdi_q <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          GAP: begin
            if (cnt == '0) begin
              state       <= IDLE;
              cmd_ready_q <= 1'b1;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              aborted_q   <= abort_q;
              // rx was cleared on accept, so len samples land right-aligned with zero upper bits
              if (read_q && !abort_q) begin
                rsp_valid_q <= 1'b1;
                for (int i = 0; i < NUM_CH; i++)
                  rsp_q[i*DATA_W +: DATA_W] <= mask_q[i] ? rx[i] : '0;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
